bullet_scheduler: RTL and testbench

Owns the bullet table (NUM_SLOTS slots). Each frame it walks every slot once, moving active bullets by their velocity and retiring those that leave the arena. Game logic spawns bullets through a valid/ready handshake; the slot is allocated by this block. The renderer reads slots through an indexed, registered read port, position/size/color/isRender per slot.

---
 rtl/bullet_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_bullet_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_scheduler.sv
// rtl/bullet_scheduler.sv - bullet table owner: per-frame motion walk, spawn allocation, renderer read port
//
// Purpose:
//   Holds NUM_SLOTS bullet slots. On each frame_tick the table is walked one
//   slot per cycle; active bullets are moved by their velocity and retired
//   when they leave the arena. Spawns are accepted only between walks and go
//   to the lowest-numbered free slot.
//
// Optional feature macro: BULLET_BOUNCE_EN
//   When defined, an out-of-range axis reflects instead of retiring: that
//   axis's velocity is negated and its coordinate is clamped to the bound it
//   crossed.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   frame_tick            start-of-vblank pulse, requests a walk
//   spawn_valid/ready     spawn handshake; spawn_x/y/xsize/ysize/color/vx/vy fields
//   spawn_slot            slot written by the last accepted spawn
//   rd_index              renderer slot select (1-cycle registered read)
//   rd_position/size      {x,y} / {xsize,ysize} of the selected slot
//   rd_color/rd_isRender  color / active flag of the selected slot
//   busy                  walk in progress
//   frame_done            one-cycle pulse after the walk finishes
//   active_count          number of active slots
//   overrun               sticky: a frame_tick was dropped

module bullet_scheduler #(
    parameter int NUM_SLOTS  = 8,
    parameter int ARENA_XMIN = 0,
    parameter int ARENA_XMAX = 159,
    parameter int ARENA_YMIN = 0,
    parameter int ARENA_YMAX = 119
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_tick,
    input  logic                         spawn_valid,
    output logic                         spawn_ready,
    input  logic [7:0]                   spawn_x,
    input  logic [7:0]                   spawn_y,
    input  logic [7:0]                   spawn_xsize,
    input  logic [7:0]                   spawn_ysize,
    input  logic [2:0]                   spawn_color,
    input  logic [3:0]                   spawn_vx,
    input  logic [3:0]                   spawn_vy,
    output logic [$clog2(NUM_SLOTS)-1:0] spawn_slot,
    input  logic [$clog2(NUM_SLOTS)-1:0] rd_index,
    output logic [15:0]                  rd_position,
    output logic [15:0]                  rd_size,
    output logic [2:0]                   rd_color,
    output logic                         rd_isRender,
    output logic                         busy,
    output logic                         frame_done,
    output logic [$clog2(NUM_SLOTS):0]   active_count,
    output logic                         overrun
);

    localparam int IW = $clog2(NUM_SLOTS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLOTS - 1);

    localparam logic signed [9:0] XMIN10 = 10'(ARENA_XMIN);
    localparam logic signed [9:0] XMAX10 = 10'(ARENA_XMAX);
    localparam logic signed [9:0] YMIN10 = 10'(ARENA_YMIN);
    localparam logic signed [9:0] YMAX10 = 10'(ARENA_YMAX);

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [7:0]           t_x     [NUM_SLOTS];
    logic [7:0]           t_y     [NUM_SLOTS];
    logic [7:0]           t_xsize [NUM_SLOTS];
    logic [7:0]           t_ysize [NUM_SLOTS];
    logic [2:0]           t_color [NUM_SLOTS];
    logic [3:0]           t_vx    [NUM_SLOTS];
    logic [3:0]           t_vy    [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] t_act;

    logic [IW-1:0] idx;
    logic          pending;

    logic          free_found;
    logic [IW-1:0] free_idx;
    logic          spawn_fire;

    logic signed [9:0] nx, ny;
    logic x_lo, x_hi, y_lo, y_hi;
    logic x_out, y_out;

    // Lowest-numbered inactive slot: scanning downward lets the last hit win.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!t_act[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        active_count = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            active_count = active_count + (IW + 1)'(t_act[i]);
        end
    end

    // Gating with reset keeps spawn_ready low while reset is held.
    assign spawn_ready = (state == IDLE) && free_found && !reset;
    assign spawn_fire  = spawn_valid && spawn_ready;
    assign busy        = (state == UPDATE);

    // Candidate position of the slot under the walk pointer, in 10-bit signed
    // so that both underflow below 0 and overflow past 255 are visible.
    always_comb begin
        nx = $signed({2'b00, t_x[idx]}) + $signed({{6{t_vx[idx][3]}}, t_vx[idx]});
        ny = $signed({2'b00, t_y[idx]}) + $signed({{6{t_vy[idx][3]}}, t_vy[idx]});
        x_lo  = (nx < XMIN10);
        x_hi  = (nx > XMAX10);
        y_lo  = (ny < YMIN10);
        y_hi  = (ny > YMAX10);
        x_out = x_lo || x_hi;
        y_out = y_lo || y_hi;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_tick || pending) state_nxt = UPDATE;
            UPDATE:  if (idx == LAST_IDX)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            frame_done  <= 1'b0;
            spawn_slot  <= '0;
            rd_position <= '0;
            rd_size     <= '0;
            rd_color    <= '0;
            rd_isRender <= 1'b0;
            t_act       <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                t_x[i]     <= '0;
                t_y[i]     <= '0;
                t_xsize[i] <= '0;
                t_ysize[i] <= '0;
                t_color[i] <= '0;
                t_vx[i]    <= '0;
                t_vy[i]    <= '0;
            end
        end else begin
            state      <= state_nxt;
            frame_done <= (state == UPDATE) && (idx == LAST_IDX);
            idx        <= (state == UPDATE) ? idx + 1'b1 : '0;

            // One tick may queue behind a running walk; any further tick is lost.
            if (state == UPDATE) begin
                if (frame_tick) begin
                    if (pending) overrun <= 1'b1;
                    else         pending <= 1'b1;
                end
            end else if (state_nxt == UPDATE) begin
                pending <= 1'b0;
            end

            if (spawn_fire) begin
                t_x[free_idx]     <= spawn_x;
                t_y[free_idx]     <= spawn_y;
                t_xsize[free_idx] <= spawn_xsize;
                t_ysize[free_idx] <= spawn_ysize;
                t_color[free_idx] <= spawn_color;
                t_vx[free_idx]    <= spawn_vx;
                t_vy[free_idx]    <= spawn_vy;
                t_act[free_idx]   <= 1'b1;
                spawn_slot        <= free_idx;
            end

            if ((state == UPDATE) && t_act[idx]) begin
`ifdef BULLET_BOUNCE_EN
                if (x_out) begin
                    t_vx[idx] <= -t_vx[idx];
                    t_x[idx]  <= x_lo ? 8'(ARENA_XMIN) : 8'(ARENA_XMAX);
                end else begin
                    t_x[idx]  <= nx[7:0];
                end
                if (y_out) begin
                    t_vy[idx] <= -t_vy[idx];
                    t_y[idx]  <= y_lo ? 8'(ARENA_YMIN) : 8'(ARENA_YMAX);
                end else begin
                    t_y[idx]  <= ny[7:0];
                end
`else
                if (x_out || y_out) begin
                    t_act[idx] <= 1'b0;
                end else begin
                    t_x[idx] <= nx[7:0];
                    t_y[idx] <= ny[7:0];
                end
`endif
            end

            rd_position <= {t_x[rd_index], t_y[rd_index]};
            rd_size     <= {t_xsize[rd_index], t_ysize[rd_index]};
            rd_color    <= t_color[rd_index];
            rd_isRender <= t_act[rd_index];
        end
    end

endmodule

// File: tb/tb_bullet_scheduler.sv
// tb/tb_bullet_scheduler.sv - self-checking bench for bullet_scheduler against a behavioural bullet model

module tb_bullet_scheduler;

    localparam int N    = 8;
    localparam int XMIN = 0;
    localparam int XMAX = 159;
    localparam int YMIN = 0;
    localparam int YMAX = 119;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       spawn_valid;
    logic       spawn_ready;
    logic [7:0] spawn_x, spawn_y, spawn_xsize, spawn_ysize;
    logic [2:0] spawn_color;
    logic [3:0] spawn_vx, spawn_vy;
    logic [2:0] spawn_slot;
    logic [2:0] rd_index;
    logic [15:0] rd_position, rd_size;
    logic [2:0] rd_color;
    logic       rd_isRender;
    logic       busy;
    logic       frame_done;
    logic [3:0] active_count;
    logic       overrun;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural bullet table
    bit m_act [N];
    int m_x [N], m_y [N], m_xs [N], m_ys [N], m_c [N], m_vx [N], m_vy [N];

    always #5 clk = ~clk;

    bullet_scheduler #(
        .NUM_SLOTS(N), .ARENA_XMIN(XMIN), .ARENA_XMAX(XMAX),
        .ARENA_YMIN(YMIN), .ARENA_YMAX(YMAX)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
        .spawn_x(spawn_x), .spawn_y(spawn_y),
        .spawn_xsize(spawn_xsize), .spawn_ysize(spawn_ysize),
        .spawn_color(spawn_color), .spawn_vx(spawn_vx), .spawn_vy(spawn_vy),
        .spawn_slot(spawn_slot), .rd_index(rd_index),
        .rd_position(rd_position), .rd_size(rd_size), .rd_color(rd_color),
        .rd_isRender(rd_isRender), .busy(busy), .frame_done(frame_done),
        .active_count(active_count), .overrun(overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_act[i]);
        return c;
    endfunction

    function automatic int model_free();
        for (int i = 0; i < N; i++) if (!m_act[i]) return i;
        return -1;
    endfunction

    function automatic int s4(input logic [3:0] v);
        return (v >= 8) ? int'(v) - 16 : int'(v);
    endfunction

    function automatic int neg4(input int v);
        return (v == -8) ? -8 : -v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_xs[i] = 0;
            m_ys[i] = 0; m_c[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
        end
    endtask

    function automatic int model_spawn();
        int s = model_free();
        m_act[s] = 1;
        m_x[s] = int'(spawn_x); m_y[s] = int'(spawn_y);
        m_xs[s] = int'(spawn_xsize); m_ys[s] = int'(spawn_ysize);
        m_c[s] = int'(spawn_color);
        m_vx[s] = s4(spawn_vx); m_vy[s] = s4(spawn_vy);
        return s;
    endfunction

    task automatic model_frame();
        for (int i = 0; i < N; i++) begin
            if (m_act[i]) begin
                int nx = m_x[i] + m_vx[i];
                int ny = m_y[i] + m_vy[i];
                bit xo = (nx < XMIN) || (nx > XMAX);
                bit yo = (ny < YMIN) || (ny > YMAX);
`ifdef BULLET_BOUNCE_EN
                if (xo) begin
                    m_x[i] = (nx < XMIN) ? XMIN : XMAX;
                    m_vx[i] = neg4(m_vx[i]);
                end else m_x[i] = nx;
                if (yo) begin
                    m_y[i] = (ny < YMIN) ? YMIN : YMAX;
                    m_vy[i] = neg4(m_vy[i]);
                end else m_y[i] = ny;
`else
                if (xo || yo) m_act[i] = 0;
                else begin
                    m_x[i] = nx;
                    m_y[i] = ny;
                end
`endif
            end
        end
    endtask

    task automatic set_fields(input int x, input int y, input int vx, input int vy);
        spawn_x = 8'(x); spawn_y = 8'(y);
        spawn_vx = 4'(vx); spawn_vy = 4'(vy);
        spawn_xsize = 8'($urandom_range(1, 255));
        spawn_ysize = 8'($urandom_range(1, 255));
        spawn_color = 3'($urandom_range(0, 7));
    endtask

    task automatic do_spawn(input int x, input int y, input int vx, input int vy);
        int s;
        set_fields(x, y, vx, vy);
        spawn_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (spawn_ready) break;
            tick();
        end
        chk("spawn_ready_wait", spawn_ready, 1);
        if (spawn_ready) begin
            tick();
            s = model_spawn();
            chk("spawn_slot", spawn_slot, s);
        end
        spawn_valid = 1'b0;
    endtask

    task automatic wait_done(output int cnt, output bit seen);
        cnt = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (frame_done) begin
                seen = 1;
                break;
            end
            if (busy) cnt++;
            tick();
        end
    endtask

    task automatic check_table();
        for (int s = 0; s < N; s++) begin
            rd_index = 3'(s);
            tick();
            chk("rd_isRender", rd_isRender, m_act[s]);
            chk("rd_position", rd_position, (m_x[s] << 8) | m_y[s]);
            chk("rd_size", rd_size, (m_xs[s] << 8) | m_ys[s]);
            chk("rd_color", rd_color, m_c[s]);
        end
        chk("active_count", active_count, model_count());
    endtask

    task automatic do_frame();
        int c;
        bit seen;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        wait_done(c, seen);
        chk("frame_done_seen", seen, 1);
        chk("busy_cycles", c, N);
        chk("busy_low_at_done", busy, 0);
        model_frame();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        model_clear();
    endtask

    initial begin
        int c;
        bit seen;
        reset = 1'b1; frame_tick = 1'b0; spawn_valid = 1'b0; rd_index = '0;
        set_fields(0, 0, 0, 0);
        model_clear();

        // Reset state
        repeat (3) tick();
        chk("rst_spawn_ready", spawn_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_active_count", active_count, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_rd_position", rd_position, 0);
        chk("rst_rd_isRender", rd_isRender, 0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", spawn_ready, 1);

        // Three identical spawns
        for (int i = 0; i < 3; i++) do_spawn(10, 20, 2, -1);
        chk("three_active", active_count, 3);
        rd_index = 3'd1;
        tick();
        chk("slot1_position", rd_position, 16'h0A14);

        // One frame moves slot 0 to (12,19)
        do_frame();
        tick();
        chk("frame_done_one_cycle", frame_done, 0);
        rd_index = 3'd0;
        tick();
        chk("slot0_moved", rd_position, 16'h0C13);
        check_table();

        // Bullet at right edge
        do_spawn(158, 40, 3, 0);
        do_frame();
        rd_index = 3'd3;
        tick();
`ifdef BULLET_BOUNCE_EN
        chk("edge_bounce_active", rd_isRender, 1);
        chk("edge_bounce_x", rd_position, 16'h9F28);
        chk("edge_bounce_count", active_count, 4);
`else
        chk("edge_retired", rd_isRender, 0);
        chk("edge_count", active_count, 3);
`endif
        check_table();

        // Fill the table; slot 5 is placed so it leaves on the next frame
        while (model_count() < N) begin
            if (model_free() == 5) do_spawn(159, 60, 1, 0);
            else                   do_spawn(80, 60, 0, 0);
        end
        chk("full_count", active_count, N);
        set_fields(50, 50, 0, 0);
        spawn_valid = 1'b1;
        #1;
        chk("full_not_ready", spawn_ready, 0);
        do_frame();
        chk("ready_after_retire", spawn_ready, model_count() < N);
        if (spawn_ready) begin
            int s;
            tick();
            s = model_spawn();
            chk("held_spawn_slot", spawn_slot, s);
`ifndef BULLET_BOUNCE_EN
            chk("held_spawn_slot5", spawn_slot, 5);
`endif
        end
        spawn_valid = 1'b0;
        check_table();

        // Reset in the middle of a walk
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        tick();
        do_reset();
        chk("midwalk_reset_busy", busy, 0);
        chk("midwalk_reset_count", active_count, 0);

        // Spawn and frame_tick in the same cycle
        set_fields(50, 60, 1, 0);
        spawn_valid = 1'b1;
        frame_tick = 1'b1;
        #1;
        chk("same_cycle_ready", spawn_ready, 1);
        tick();
        spawn_valid = 1'b0;
        frame_tick = 1'b0;
        chk("same_cycle_slot", spawn_slot, model_spawn());
        wait_done(c, seen);
        chk("same_cycle_done", seen, 1);
        chk("same_cycle_busy", c, N);
        model_frame();
        rd_index = 3'd0;
        tick();
        chk("same_cycle_x51", rd_position, 16'h333C);
        chk("no_overrun_yet", overrun, 0);
        check_table();

        // Two extra ticks during one walk
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        wait_done(c, seen);
        chk("ovr_first_done", seen, 1);
        model_frame();
        tick();
        chk("ovr_second_walk", busy, 1);
        wait_done(c, seen);
        chk("ovr_second_done", seen, 1);
        chk("ovr_second_busy", c, N);
        model_frame();
        repeat (3) tick();
        chk("ovr_no_third_walk", busy, 0);
        chk("overrun_set", overrun, 1);
        check_table();

        // Randomised spawns and frames against the model
        do_reset();
        chk("overrun_cleared", overrun, 0);
        for (int it = 0; it < 40; it++) begin
            chk("rand_ready", spawn_ready, model_count() < N);
            if (($urandom_range(0, 2) == 0) || (model_count() == N)) begin
                do_frame();
                check_table();
            end else begin
                do_spawn($urandom_range(0, 170), $urandom_range(0, 130),
                         $urandom_range(0, 15), $urandom_range(0, 15));
            end
        end
        do_frame();
        check_table();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
